// File: rtl/vm_pkg.sv
// Shared vending-machine types and constants: FSM state encoding, default
// datapath sizing and the standard coin denominations in NIS.
package vm_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HAS_CREDIT = 2'd1,
    DISPENSE   = 2'd2
  } vm_state_t;

  localparam int DEFAULT_WIDTH      = 5;
  localparam int DEFAULT_MAX_CREDIT = 31;

  localparam logic [DEFAULT_WIDTH-1:0] COIN_1  = DEFAULT_WIDTH'(1);
  localparam logic [DEFAULT_WIDTH-1:0] COIN_2  = DEFAULT_WIDTH'(2);
  localparam logic [DEFAULT_WIDTH-1:0] COIN_5  = DEFAULT_WIDTH'(5);
  localparam logic [DEFAULT_WIDTH-1:0] COIN_10 = DEFAULT_WIDTH'(10);

endpackage

// File: rtl/credit_accumulator_if.sv
// Request/response bundle between the coin front-end (master) and the
// credit accumulator (slave).
interface credit_accumulator_if #(parameter int WIDTH = 5);

  logic             coin_valid;
  logic [WIDTH-1:0] coin_value;
  logic             purchase_req;
  logic [WIDTH-1:0] price;
  logic             refund_req;
  logic [WIDTH-1:0] credit;
  logic             coin_reject;
  logic             overflow;
  logic             vend_ok;
  logic             vend_denied;
  logic             change_valid;
  logic [WIDTH-1:0] change_amount;
  logic             busy;

  modport master (
    output coin_valid, coin_value, purchase_req, price, refund_req,
    input  credit, coin_reject, overflow, vend_ok, vend_denied,
           change_valid, change_amount, busy
  );

  modport slave (
    input  coin_valid, coin_value, purchase_req, price, refund_req,
    output credit, coin_reject, overflow, vend_ok, vend_denied,
           change_valid, change_amount, busy
  );

endinterface

// File: rtl/credit_accumulator_dispense_timer.sv
// Load/count-down timer that measures the dispense window; done flags the
// last busy cycle so the FSM can leave DISPENSE on that edge.
module dispense_timer #(
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count_en,
  output logic done
);

  localparam int CW = $clog2(DISPENSE_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(DISPENSE_CYCLES);
    end else if (count_en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == CW'(1));

endmodule

// File: rtl/credit_accumulator.sv
// Registered credit store for the vending machine: accepts coins up to
// MAX_CREDIT, handles purchase/refund, and holds busy while product drops.
module credit_accumulator
  import vm_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int MAX_CREDIT      = DEFAULT_MAX_CREDIT,
  parameter int DISPENSE_CYCLES = 4,
  parameter int AUTO_CHANGE     = 0
) (
  input logic                 clk,
  input logic                 rst,
  credit_accumulator_if.slave bus
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX_CREDIT);

  vm_state_t        state;
  logic [WIDTH-1:0] credit;
  logic [WIDTH-1:0] change_amount;
  logic             coin_reject;
  logic             overflow;
  logic             vend_ok;
  logic             vend_denied;
  logic             change_valid;
  logic             busy;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] remainder;
  logic             price_ok;
  logic             vend_go;
  logic             timer_done;

  // One extra bit on the sum so an oversized coin is seen instead of wrapping.
  assign sum       = {1'b0, credit} + {1'b0, bus.coin_value};
  assign remainder = credit - bus.price;
  assign price_ok  = (bus.price != '0) && (credit >= bus.price);
  assign vend_go   = (state != DISPENSE) && !bus.refund_req && bus.purchase_req && price_ok;

  dispense_timer #(
    .DISPENSE_CYCLES(DISPENSE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (vend_go),
    .count_en (state == DISPENSE),
    .done     (timer_done)
  );

  // Priority outside DISPENSE is refund, then purchase, then coin; a coin that
  // loses to a refund or purchase is handed back without an overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      credit        <= '0;
      change_amount <= '0;
      coin_reject   <= 1'b0;
      overflow      <= 1'b0;
      vend_ok       <= 1'b0;
      vend_denied   <= 1'b0;
      change_valid  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      overflow     <= 1'b0;
      vend_ok      <= 1'b0;
      vend_denied  <= 1'b0;
      change_valid <= 1'b0;
      case (state)
        DISPENSE: begin
          if (bus.coin_valid) coin_reject <= 1'b1;
          if (timer_done) begin
            busy  <= 1'b0;
            state <= (credit != '0) ? HAS_CREDIT : IDLE;
          end
        end
        default: begin
          if (bus.refund_req) begin
            if (bus.coin_valid) coin_reject <= 1'b1;
            if (credit != '0) begin
              change_valid  <= 1'b1;
              change_amount <= credit;
              credit        <= '0;
            end
            state <= IDLE;
          end else if (bus.purchase_req) begin
            if (bus.coin_valid) coin_reject <= 1'b1;
            if (price_ok) begin
              vend_ok <= 1'b1;
              busy    <= 1'b1;
              state   <= DISPENSE;
              if (AUTO_CHANGE != 0) begin
                credit <= '0;
                if (remainder != '0) begin
                  change_valid  <= 1'b1;
                  change_amount <= remainder;
                end
              end else begin
                credit <= remainder;
              end
            end else begin
              vend_denied <= 1'b1;
            end
          end else if (bus.coin_valid) begin
            if (sum <= MAX_EXT) begin
              credit <= sum[WIDTH-1:0];
              state  <= (sum != '0) ? HAS_CREDIT : IDLE;
            end else begin
              coin_reject <= 1'b1;
              overflow    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.credit        = credit;
  assign bus.coin_reject   = coin_reject;
  assign bus.overflow      = overflow;
  assign bus.vend_ok       = vend_ok;
  assign bus.vend_denied   = vend_denied;
  assign bus.change_valid  = change_valid;
  assign bus.change_amount = change_amount;
  assign bus.busy          = busy;

endmodule

// File: doc/credit_accumulator.md
Name: credit_accumulator

Overview:
- Registered, parametrised credit accumulator for the vending machine datapath. It is the sequential successor to the 5-bit combinational amount store.
- Accepts coin deposits, enforces a maximum credit, processes purchase and refund requests, and returns change.
- Holds a dispense-busy window while product is released.
- Sits between the coin front-end and the product/change dispenser controllers.

Parameters:
- WIDTH, 5, bit width of credit, coin_value, price, change_amount.
- MAX_CREDIT, 31, largest storable credit. Must be ≤ 2^WIDTH-1.
- DISPENSE_CYCLES, 4, cycles busy is held after a successful vend. Must be ≥ 1.
- AUTO_CHANGE, 0. 1: remainder is returned automatically after a vend. 0: remainder stays as credit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coin_valid  in  1  one-cycle strobe, coin presented.
- coin_value  in  WIDTH  coin value in NIS.
- purchase_req  in  1  one-cycle strobe, purchase requested.
- price  in  WIDTH  price of the selected item, sampled with purchase_req.
- refund_req  in  1  one-cycle strobe, return all credit.
- credit  out  WIDTH  current stored credit.
- coin_reject  out  1  pulse, coin not accepted (return it).
- overflow  out  1  pulse, rejection was due to exceeding MAX_CREDIT.
- vend_ok  out  1  pulse, purchase accepted.
- vend_denied  out  1  pulse, insufficient credit or price==0.
- change_valid  out  1  pulse, change_amount is valid.
- change_amount  out  WIDTH  change to dispense.
- busy  out  1  high during DISPENSE.

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled on rising clk.
- Reset: credit=0, all pulse outputs=0, change_amount=0, busy=0, state=IDLE, dispense counter=0. Reset asserted mid-dispense aborts immediately; no change is emitted.
- All outputs are registered. Every response pulse appears exactly 1 cycle after the sampled request and lasts 1 cycle.
- FSM states:
  - IDLE: credit==0.
  - HAS_CREDIT: credit>0.
  - DISPENSE: busy=1.
- Arithmetic: the sum credit+coin_value is computed in WIDTH+1 bits, so it never wraps. Subtraction is only performed when credit ≥ price.
- Per-cycle priority in IDLE/HAS_CREDIT: refund_req > purchase_req > coin_valid.
- Coin handling:
  - If the sum ≤ MAX_CREDIT: credit ← sum.
  - Else: credit unchanged, coin_reject=1, overflow=1.
  - A coin presented in the same cycle as a refund or purchase is rejected (coin_reject=1, overflow=0).
- Purchase:
  - If price≠0 and credit ≥ price: vend_ok=1 and the FSM enters DISPENSE.
    - AUTO_CHANGE=0: credit ← credit-price.
    - AUTO_CHANGE=1: change_valid=1, change_amount=credit-price, credit ← 0. change_valid is suppressed when the remainder is 0.
  - Otherwise: vend_denied=1, credit unchanged.
- Refund:
  - If credit>0: change_valid=1, change_amount=credit, credit ← 0, next state IDLE.
  - If credit==0: no outputs.
- DISPENSE:
  - busy=1 for exactly DISPENSE_CYCLES cycles, starting the cycle vend_ok is high.
  - Coins are rejected (coin_reject=1, overflow=0).
  - purchase_req and refund_req are ignored, with no response pulse.
  - Exit goes to HAS_CREDIT if credit>0, else IDLE.
- change_amount holds its last value when change_valid=0.
- Credit exactly equal to MAX_CREDIT is legal. A coin of value 0 is accepted with no change and no pulse.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (IDLE, HAS_CREDIT, DISPENSE);
  - default WIDTH and MAX_CREDIT constants;
  - standard coin value constants (1, 2, 5, 10 NIS).
- One sub-module is natural: dispense_timer, a load/count-down counter with a done flag, parametrised by DISPENSE_CYCLES.

Test Plan:
1. Reset, then coins 10, 5, 10, 5: credit 10, 15, 25, 30, no rejects. A further coin 2 gives coin_reject=1, overflow=1, credit stays 30. Then coin 1 gives credit 31 (MAX, accepted).
2. credit=15, purchase price=12, AUTO_CHANGE=0:
   - vend_ok pulse, credit=3;
   - busy high for 4 cycles;
   - a coin of 5 during busy gives coin_reject=1, overflow=0;
   - credit returns to HAS_CREDIT with value 3.
3. AUTO_CHANGE=1, credit=20, price=7: vend_ok=1, change_valid=1, change_amount=13, credit=0, state IDLE after busy ends.
4. credit=5, price=10: vend_denied=1, credit=5. Then price=0: vend_denied=1.
5. credit=9, refund_req and coin_valid (value 2) in the same cycle: change_valid=1, change_amount=9, coin_reject=1, credit=0.
6. Reset asserted during DISPENSE cycle 2: next cycle busy=0, credit=0, no pulses, state IDLE.
7. Refund with credit=0: no change_valid.
